// File: rtl/vga_pkg.sv
// Shared frame-buffer definitions and the reset/enable flop macros used by the write path.
`ifndef FB_FF_R
`define FB_FF_R(clk, rstn, q, d, rv) \
  always_ff @(posedge clk) begin \
    if (!(rstn)) q <= (rv); \
    else q <= (d); \
  end
`endif

`ifndef FB_FF_RE
`define FB_FF_RE(clk, rstn, en, q, d, rv) \
  always_ff @(posedge clk) begin \
    if (!(rstn)) q <= (rv); \
    else if (en) q <= (d); \
  end
`endif

package vga_pkg;

  // 80 words per row x 96 rows
  localparam int FB_WORDS_DEF = 7680;
  localparam int ADDR_W_DEF   = 13;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_wr_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to the pointer.
module rr_arb2
  import vga_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Grant mux; the pointer only matters when both requesters compete
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_wr_arb.sv
// Frame-buffer write arbiter: fills the buffer with a pattern after reset or on request,
// otherwise round-robins two requesters onto a single registered RAM write port.
module fb_wr_arb
  import vga_pkg::*;
#(
  parameter int FB_WORDS = FB_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
)
(
  input  logic              CLK_25,
  input  logic              ResetN,
  input  logic              WrAllow,
  input  logic              ClrReq,
  input  logic [31:0]       ClrData,
  output logic              ClrBusy,
  output logic              ClrDone,
  input  logic [1:0]        ReqValid,
  input  logic [ADDR_W-1:0] ReqAddr0,
  input  logic [ADDR_W-1:0] ReqAddr1,
  input  logic [31:0]       ReqData0,
  input  logic [31:0]       ReqData1,
  output logic [1:0]        ReqReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddress,
  output logic [31:0]       WrData
);

  // One extra counter bit lets FB_WORDS reach 2^ADDR_W without the compare wrapping
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(FB_WORDS - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
  logic [31:0]       pattern_q;
  logic              load_pattern;
  logic              ptr_q;
  logic [1:0]        grant;
  logic [1:0]        handshake;
  logic              serve_open;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic              clr_done_d;

  rr_arb2 u_rr_arb2 (
    .valid   (ReqValid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  // Requesters are only offered the port in SERVE, inside the write window, and never
  // in a cycle where a clear is being requested (the clear wins that cycle).
  assign serve_open = (state_q == SERVE) && WrAllow && !ClrReq;
  assign ReqReady   = serve_open ? grant : 2'b00;
  assign handshake  = ReqValid & ReqReady;
  assign ClrBusy    = (state_q == CLEAR);

  // Next-state, clear counter and the write that will be registered at the next edge
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    load_pattern = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    clr_done_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        if (WrAllow) begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_addr_q[ADDR_W-1:0];
          wr_data_d = pattern_q;
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = SERVE;
            clr_addr_d = '0;
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + (ADDR_W+1)'(1);
          end
        end
      end
      SERVE: begin
        if (ClrReq) begin
          state_d      = CLEAR;
          clr_addr_d   = '0;
          load_pattern = 1'b1;
        end else if (handshake[0]) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ReqAddr0;
          wr_data_d = ReqData0;
        end else if (handshake[1]) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ReqAddr1;
          wr_data_d = ReqData1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // FSM state register; reset always restarts a blanking fill
  `FB_FF_R(CLK_25, ResetN, state_q, state_d, CLEAR)

  // Clear address counter
  `FB_FF_R(CLK_25, ResetN, clr_addr_q, clr_addr_d, '0)

  // Fill pattern, captured only when a clear is accepted
  `FB_FF_RE(CLK_25, ResetN, load_pattern, pattern_q, ClrData, 32'h0)

  // Round-robin pointer flips to the other requester after every completed handshake
  `FB_FF_RE(CLK_25, ResetN, |handshake, ptr_q, handshake[0], 1'b0)

  // Registered RAM write enable
  `FB_FF_R(CLK_25, ResetN, WrEn, wr_en_d, 1'b0)

  // Registered RAM write address (zero when idle)
  `FB_FF_R(CLK_25, ResetN, WrAddress, wr_addr_d, '0)

  // Registered RAM write data (zero when idle)
  `FB_FF_R(CLK_25, ResetN, WrData, wr_data_d, 32'h0)

  // End-of-clear pulse, coincident with the first SERVE cycle
  `FB_FF_R(CLK_25, ResetN, ClrDone, clr_done_d, 1'b0)

endmodule
